tc77_reader: RTL

// Master-side SPI reader for the TC77 board temperature sensor. Periodically (or on trigger)

---
 rtl/tc77_reader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/tc77_reader.sv
// tc77_reader: SPI master that frames 16-bit reads from a TC77 sensor and publishes
// the reading, integer degrees and a hysteretic over-temperature flag.
module tc77_reader #(
    parameter int                SCK_HALF    = 8,
    parameter int                POLL_CYCLES = 4800000,
    parameter int                CS_GAP      = 16,
    parameter logic signed [8:0] TEMP_HI     = 9'sd35,
    parameter logic signed [8:0] TEMP_LO     = 9'sd30
) (
    input  logic               MCLK,
    input  logic               nRESET,
    input  logic               i_POLL_EN,
    input  logic               i_TRIG,
    output logic               o_nCS,
    output logic               o_SCK,
    input  logic               i_SIO,
    output logic               o_BUSY,
    output logic signed [12:0] o_TEMP_RAW,
    output logic signed [8:0]  o_TEMP_DEG,
    output logic               o_TEMP_VALID,
    output logic               o_UPDATE,
    output logic               o_NOTREADY,
    output logic               o_OVERTEMP
);
    localparam int CNT_MAX = (SCK_HALF > CS_GAP) ? SCK_HALF : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PC_W    = $clog2(POLL_CYCLES + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SCK_HALF - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_GAP - 1);
    localparam logic [PC_W-1:0]  POLL_LAST = PC_W'(POLL_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, LO, HI, GAP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_cnt;
    logic [PC_W-1:0]  poll_cnt;
    logic             pending;
    logic             sio_meta, sio_sync;
    logic [13:0]      frame_bits;   // word bits [15:2]: temperature then conversion flag
    logic             start;

    function automatic logic signed [8:0] to_degrees(input logic signed [12:0] raw);
        return $signed(raw[12:4]);
    endfunction

    function automatic logic next_overtemp(input logic signed [8:0] deg, input logic cur);
        if (deg > TEMP_HI) return 1'b1;
        if (deg < TEMP_LO) return 1'b0;
        return cur;
    endfunction

    assign start = (i_POLL_EN && poll_cnt == POLL_LAST) || pending || i_TRIG;

    always_ff @(posedge MCLK) begin
        sio_meta <= i_SIO;
        sio_sync <= sio_meta;
    end

    // Only the first 14 sampled bits matter; bits [1:0] of the word are never stored.
    always_ff @(posedge MCLK) begin
        if (state == HI && cnt == HALF_LAST && bit_cnt <= 4'd13)
            frame_bits <= {frame_bits[12:0], sio_sync};
    end

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            poll_cnt     <= '0;
            pending      <= 1'b0;
            o_nCS        <= 1'b1;
            o_SCK        <= 1'b1;
            o_BUSY       <= 1'b0;
            o_TEMP_RAW   <= '0;
            o_TEMP_DEG   <= '0;
            o_TEMP_VALID <= 1'b0;
            o_UPDATE     <= 1'b0;
            o_NOTREADY   <= 1'b0;
            o_OVERTEMP   <= 1'b0;
        end else begin
            o_UPDATE <= 1'b0;
            if (i_TRIG && state != IDLE) pending <= 1'b1;
            // An expiry that lands mid-frame is held until the FSM returns to IDLE.
            if (!i_POLL_EN) poll_cnt <= '0;
            else if (poll_cnt != POLL_LAST) poll_cnt <= poll_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SETUP;
                        o_nCS    <= 1'b0;
                        o_BUSY   <= 1'b1;
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        pending  <= 1'b0;
                        poll_cnt <= '0;
                    end
                end
                SETUP: begin
                    if (cnt == HALF_LAST) begin
                        state <= LO;
                        o_SCK <= 1'b0;
                        cnt   <= '0;
                    end else cnt <= cnt + 1'b1;
                end
                LO: begin
                    if (cnt == HALF_LAST) begin
                        state <= HI;
                        o_SCK <= 1'b1;
                        cnt   <= '0;
                    end else cnt <= cnt + 1'b1;
                end
                HI: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (bit_cnt == 4'd15) begin
                            state <= GAP;
                            o_nCS <= 1'b1;
                            if (frame_bits[0]) begin
                                o_TEMP_RAW   <= $signed(frame_bits[13:1]);
                                o_TEMP_DEG   <= to_degrees($signed(frame_bits[13:1]));
                                o_TEMP_VALID <= 1'b1;
                                o_NOTREADY   <= 1'b0;
                                o_UPDATE     <= 1'b1;
                                o_OVERTEMP   <= next_overtemp(to_degrees($signed(frame_bits[13:1])),
                                                              o_OVERTEMP);
                            end else begin
                                o_NOTREADY <= 1'b1;
                            end
                        end else begin
                            state   <= LO;
                            o_SCK   <= 1'b0;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else cnt <= cnt + 1'b1;
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state  <= IDLE;
                        o_BUSY <= 1'b0;
                        cnt    <= '0;
                    end else cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
